// File: rtl/key_synth.sv
// Polyphonic-key monophonic tone generator: per-key debounce, lowest-index priority, square-wave output.
// Optional sustain tail enabled by defining KEY_SYNTH_SUSTAIN_EN.
module key_synth #(
  parameter int NUM_KEYS        = 8,
  parameter int CNT_WIDTH       = 17,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SUSTAIN_CYCLES  = 5000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_KEYS-1:0]           keys,
  input  logic [NUM_KEYS*CNT_WIDTH-1:0] half_period,
  input  logic                          octave_up,
  output logic                          speaker,
  output logic                          note_on,
  output logic [3:0]                    active_key
);

  if (NUM_KEYS < 2 || NUM_KEYS > 16 || DEBOUNCE_CYCLES < 1 || SUSTAIN_CYCLES < 1) begin : g_param_check
    $error("key_synth: parameter out of range");
  end

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_SYNTH_SUSTAIN_EN
  localparam int SBW = $clog2(SUSTAIN_CYCLES + 1);
  localparam logic [SBW-1:0] SUS_LAST = SBW'(SUSTAIN_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PLAY, SUSTAIN} state_t;
  logic [SBW-1:0] sus_q, sus_d;
`else
  typedef enum logic {IDLE, PLAY} state_t;
`endif

  state_t                             state_q, state_d;
  logic [NUM_KEYS-1:0]                deb_q, deb_d;
  logic [NUM_KEYS-1:0][DBW-1:0]       dcnt_q, dcnt_d;
  logic [CNT_WIDTH-1:0]               cnt_q, cnt_d;
  logic                               spk_q, spk_d;
  logic                               note_q, note_d;
  logic [3:0]                         act_q, act_d;

  logic                               any_key, found;
  logic [3:0]                         sel;
  logic [CNT_WIDTH-1:0]               h_raw, h_eff, tone_cnt;
  logic                               tone_spk, do_restart, do_clear;

  // A key's counter only runs while its raw level disagrees with the accepted level.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (keys[i] != deb_q[i]) begin
        if (dcnt_q[i] == DB_LAST) deb_d[i] = ~deb_q[i];
        else                      dcnt_d[i] = dcnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    any_key = |deb_q;
    sel     = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (!found && deb_q[i]) begin
        sel   = 4'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    h_raw = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (act_q == 4'(i)) h_raw = half_period[i*CNT_WIDTH +: CNT_WIDTH];
    end
    h_eff = octave_up ? (h_raw >> 1) : h_raw;
  end

  // The >= compare keeps the counter bounded when H shrinks below the current count.
  always_comb begin
    tone_cnt = cnt_q + 1'b1;
    tone_spk = spk_q;
    if (h_eff == '0) begin
      tone_cnt = '0;
      tone_spk = 1'b0;
    end else if (cnt_q >= h_eff - 1'b1) begin
      tone_cnt = '0;
      tone_spk = ~spk_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    do_restart = 1'b0;
    do_clear   = 1'b0;
`ifdef KEY_SYNTH_SUSTAIN_EN
    sus_d      = sus_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_key) begin
          state_d    = PLAY;
          do_restart = 1'b1;
        end else begin
          do_clear = 1'b1;
        end
      end
      PLAY: begin
        if (!any_key) begin
`ifdef KEY_SYNTH_SUSTAIN_EN
          state_d = SUSTAIN;
          sus_d   = '0;
`else
          state_d  = IDLE;
          do_clear = 1'b1;
`endif
        end else if (sel != act_q) begin
          do_restart = 1'b1;
        end
      end
`ifdef KEY_SYNTH_SUSTAIN_EN
      SUSTAIN: begin
        if (any_key) begin
          state_d    = PLAY;
          do_restart = 1'b1;
        end else if (sus_q == SUS_LAST) begin
          state_d  = IDLE;
          do_clear = 1'b1;
        end else begin
          sus_d = sus_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d  = IDLE;
        do_clear = 1'b1;
      end
    endcase

    if (do_clear) begin
      cnt_d  = '0;
      spk_d  = 1'b0;
      note_d = 1'b0;
      act_d  = '0;
    end else if (do_restart) begin
      cnt_d  = '0;
      spk_d  = 1'b0;
      note_d = 1'b1;
      act_d  = sel;
    end else begin
      cnt_d  = tone_cnt;
      spk_d  = tone_spk;
      note_d = 1'b1;
      act_d  = act_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      deb_q   <= '0;
      dcnt_q  <= '0;
      cnt_q   <= '0;
      spk_q   <= 1'b0;
      note_q  <= 1'b0;
      act_q   <= '0;
`ifdef KEY_SYNTH_SUSTAIN_EN
      sus_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      cnt_q   <= cnt_d;
      spk_q   <= spk_d;
      note_q  <= note_d;
      act_q   <= act_d;
`ifdef KEY_SYNTH_SUSTAIN_EN
      sus_q   <= sus_d;
`endif
    end
  end

  assign speaker    = spk_q;
  assign note_on    = note_q;
  assign active_key = act_q;

endmodule

// File: tb/tb_key_synth.sv
// Bench for key_synth: cycle model from the behavioural rules plus directed literal checkpoints.
module tb_key_synth;
  localparam int NK  = 4;
  localparam int CW  = 8;
  localparam int DB  = 4;
  localparam int SUS = 20;
  localparam logic [NK*CW-1:0] HP0 = {8'd10, 8'd8, 8'd6, 8'd5};

  logic              clk;
  logic              reset;
  logic [NK-1:0]     keys;
  logic [NK*CW-1:0]  half_period;
  logic              octave_up;
  logic              speaker, note_on;
  logic [3:0]        active_key;

  int checks = 0;
  int errors = 0;
  int cur    = 0;

  key_synth #(
    .NUM_KEYS(NK), .CNT_WIDTH(CW), .DEBOUNCE_CYCLES(DB), .SUSTAIN_CYCLES(SUS)
  ) dut (
    .clk(clk), .reset(reset), .keys(keys), .half_period(half_period),
    .octave_up(octave_up), .speaker(speaker), .note_on(note_on), .active_key(active_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cur, $time);
    end
  endtask

  // Inputs as seen by each rising edge.
  logic [NK-1:0]    s_keys;
  logic [NK*CW-1:0] s_hp;
  logic             s_oct, s_reset;
  always @(posedge clk) begin
    s_keys  <= keys;
    s_hp    <= half_period;
    s_oct   <= octave_up;
    s_reset <= reset;
  end

  // Behavioural model: a key is accepted once its raw level has held the same
  // value for DB consecutive samples and disagrees with the accepted level.
  bit m_valid = 0;
  bit m_deb[NK];
  bit m_last[NK];
  int m_run[NK];
  int m_mode;      // 0 silent, 1 playing, 2 sustaining
  int m_phase;
  bit m_spk;
  int m_act;
  int m_age;

  task automatic m_tone(input int h);
    if (h == 0) begin
      m_phase = 0;
      m_spk   = 0;
    end else if (m_phase + 1 >= h) begin
      m_phase = 0;
      m_spk   = !m_spk;
    end else begin
      m_phase++;
    end
  endtask

  task automatic m_silence();
    m_mode = 0; m_act = 0; m_phase = 0; m_spk = 0;
  endtask

  task automatic m_start(input int k);
    m_mode = 1; m_act = k; m_phase = 0; m_spk = 0;
  endtask

  always @(negedge clk) begin
    if (s_reset === 1'b1) begin
      m_valid = 1;
      m_silence();
      m_age = 0;
      for (int i = 0; i < NK; i++) begin
        m_deb[i] = 0; m_run[i] = 0; m_last[i] = 0;
      end
    end else if (m_valid) begin
      bit any;
      int sel, h;
      any = 0; sel = 0;
      for (int i = NK - 1; i >= 0; i--) if (m_deb[i]) begin any = 1; sel = i; end
      h = int'(s_hp[m_act*CW +: CW]);
      if (s_oct) h = h / 2;
      case (m_mode)
        0: if (any) m_start(sel);
        1: begin
          if (!any) begin
`ifdef KEY_SYNTH_SUSTAIN_EN
            m_mode = 2; m_age = 0; m_tone(h);
`else
            m_silence();
`endif
          end else if (sel != m_act) m_start(sel);
          else m_tone(h);
        end
        default: begin
          if (any) m_start(sel);
          else if (m_age == SUS - 1) m_silence();
          else begin m_age++; m_tone(h); end
        end
      endcase
      for (int i = 0; i < NK; i++) begin
        if (m_run[i] > 0 && s_keys[i] == m_last[i]) m_run[i]++;
        else m_run[i] = 1;
        m_last[i] = s_keys[i];
        if (s_keys[i] != m_deb[i] && m_run[i] >= DB) m_deb[i] = s_keys[i];
      end
    end
    if (m_valid) begin
      chk("model_speaker", speaker, 32'(m_spk));
      chk("model_note_on", note_on, 32'(m_mode != 0));
      chk("model_active_key", active_key, 32'(m_act));
    end
  end

  // Assert reset for one edge, then release with the given keys in cycle 0.
  task automatic start(input logic [NK-1:0] k);
    reset = 1'b1; keys = '0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0; keys = k; cur = 0;
  endtask

  task automatic run_to(input int c);
    if (c > cur) begin
      repeat (c - cur) @(posedge clk);
      @(negedge clk);
    end
    cur = c;
  endtask

  initial begin
    reset = 1'b1; keys = '0; half_period = HP0; octave_up = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_speaker", speaker, 0);
    chk("reset_note_on", note_on, 0);
    chk("reset_active", active_key, 0);

    // Clean hold of key 2 (H=8).
    start(4'b0100);
    run_to(4);  chk("s1_note_c4", note_on, 0);
    run_to(5);  chk("s1_note_c5", note_on, 1); chk("s1_act_c5", active_key, 2);
    run_to(12); chk("s1_spk_c12", speaker, 0);
    run_to(13); chk("s1_spk_c13", speaker, 1);
    run_to(20); chk("s1_spk_c20", speaker, 1);
    run_to(21); chk("s1_spk_c21", speaker, 0);

    // Bounce 1,0,1,0 then held from cycle 4.
    start(4'b0100);
    run_to(1); keys = 4'b0000;
    run_to(2); keys = 4'b0100;
    run_to(3); keys = 4'b0000;
    run_to(4); keys = 4'b0100;
    for (int c = 5; c <= 8; c++) begin
      run_to(c); chk("s2_no_glitch", note_on, 0);
    end
    run_to(9); chk("s2_note_c9", note_on, 1);

    // Keys 3 and 1 held, key 0 added at cycle 10.
    start(4'b1010);
    run_to(5);  chk("s3_act_c5", active_key, 1);
    run_to(10); keys = 4'b1011;
    run_to(14); chk("s3_act_c14", active_key, 1); chk("s3_spk_c14", speaker, 1);
    run_to(15); chk("s3_act_c15", active_key, 0); chk("s3_spk_c15", speaker, 0);
    run_to(19); chk("s3_spk_c19", speaker, 0);
    run_to(20); chk("s3_spk_c20", speaker, 1);
    run_to(24); chk("s3_spk_c24", speaker, 1);
    run_to(25); chk("s3_spk_c25", speaker, 0);

    // Octave up on key 0 (H=2), then slice=1 mutes.
    octave_up = 1'b1;
    start(4'b0001);
    run_to(6);  chk("s4_spk_c6", speaker, 0);
    run_to(7);  chk("s4_spk_c7", speaker, 1);
    run_to(8);  chk("s4_spk_c8", speaker, 1);
    run_to(9);  chk("s4_spk_c9", speaker, 0);
    run_to(12); half_period = {8'd10, 8'd8, 8'd6, 8'd1};
    for (int c = 14; c <= 18; c += 2) begin
      run_to(c); chk("s4_mute_spk", speaker, 0); chk("s4_mute_note", note_on, 1);
    end
    run_to(20); keys = 4'b0000;
    run_to(24); chk("s4_note_c24", note_on, 1);
    run_to(25);
`ifdef KEY_SYNTH_SUSTAIN_EN
    chk("s4_note_c25", note_on, 1);
`else
    chk("s4_note_c25", note_on, 0);
`endif
    half_period = HP0; octave_up = 1'b0;

    // Reset pulsed mid-note with key still held.
    start(4'b0100);
    run_to(14); chk("s5_spk_c14", speaker, 1); reset = 1'b1;
    run_to(15); chk("s5_spk_c15", speaker, 0); chk("s5_note_c15", note_on, 0);
    chk("s5_act_c15", active_key, 0); reset = 1'b0;
    run_to(19); chk("s5_note_c19", note_on, 0);
    run_to(20); chk("s5_note_c20", note_on, 1); chk("s5_act_c20", active_key, 2);

`ifdef KEY_SYNTH_SUSTAIN_EN
    // Release into a full sustain tail.
    start(4'b0100);
    run_to(22); keys = 4'b0000;
    run_to(29); chk("s6_spk_c29", speaker, 1);
    run_to(45); chk("s6_spk_c45", speaker, 1); chk("s6_act_c45", active_key, 2);
    run_to(46); chk("s6_note_c46", note_on, 1);
    run_to(47); chk("s6_note_c47", note_on, 0); chk("s6_act_c47", active_key, 0);

    // Key 1 accepted at sustain cycle 10.
    start(4'b0100);
    run_to(22); keys = 4'b0000;
    run_to(33); keys = 4'b0010;
    run_to(37); chk("s7_act_c37", active_key, 2); chk("s7_note_c37", note_on, 1);
    run_to(38); chk("s7_act_c38", active_key, 1); chk("s7_spk_c38", speaker, 0);
    run_to(43); chk("s7_spk_c43", speaker, 0);
    run_to(44); chk("s7_spk_c44", speaker, 1);
`endif

    run_to(cur + 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
